// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the HD44780 LCD write controller:
//   - lcd_state_t     : controller FSM states
//   - CMD_CLEAR/HOME  : commands that need the long post-pulse wait
//   - INIT_ROM/LEN    : power-up command sequence, issued with RS=0
//   - needs_long_wait : selects the long wait for clear/home commands
//   - max_int         : constant helper used to size the shared counter
package lcd_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        SETUP,
        PULSE,
        WAIT,
        IDLE
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int INIT_LEN   = 5;
    localparam int INIT_IDX_W = $clog2(INIT_LEN);

    // 8-bit bus / 2 lines, display on, clear, entry mode increment
    localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear and home are the only commands the controller executes slowly
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_if.sv
// lcd_if
// Byte write channel from the CPU to the LCD controller.
//   wr_valid : producer offers a byte (held until accepted)
//   wr_data  : byte to write
//   wr_rs    : 0 = command, 1 = character data
//   wr_ready : controller accepts the byte this cycle
// Modports: master = CPU side, slave = controller side.
interface lcd_if;

    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_rs;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_rs,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_rs,
        output wr_ready
    );

endinterface

// File: rtl/lcd_timer.sv
// lcd_timer
// Loadable down-counter shared by every timed controller state.
// A loaded value N makes done rise on the N-th cycle after the load;
// a value of zero behaves like one so no state can collapse to nothing.
//   clk, rst   : clock and asynchronous active-high reset
//   load       : load load_value this edge
//   load_value : cycle count for the next timed interval
//   done       : the current interval ends this cycle
module lcd_timer #(
    parameter int               WIDTH       = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Count down to 1 and park there; reset preloads the power-up interval
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= (load_value == '0) ? WIDTH'(1) : load_value;
        end else if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count <= WIDTH'(1));

endmodule

// File: rtl/lcd_controller.sv
// lcd_controller
// HD44780 write-only controller. After reset it waits POWERUP_CYC cycles,
// plays the init ROM, then accepts CPU bytes one at a time and shapes each
// into a SETUP / EN PULSE / WAIT sequence on the LCD pins.
//   CLOCK_50  : single clock, rising edge
//   reset     : asynchronous active-high reset
//   wr        : CPU byte channel (lcd_if slave)
//   init_done : power-up init sequence has completed
//   LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON : HD44780 pins
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int EN_HIGH_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    lcd_if.slave       wr,
    output logic       init_done,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON
);

    localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, SETUP_CYC),
                                             max_int(EN_HIGH_CYC, CMD_WAIT_CYC)),
                                     max_int(CLEAR_WAIT_CYC, 1));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(POWERUP_CYC);
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] LD_EN_HIGH = CNT_W'(EN_HIGH_CYC);
    localparam logic [CNT_W-1:0] LD_CMD     = CNT_W'(CMD_WAIT_CYC);
    localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(CLEAR_WAIT_CYC);

    localparam logic [INIT_IDX_W-1:0] LAST_INIT = INIT_IDX_W'(INIT_LEN - 1);

    lcd_state_t             state;
    lcd_state_t             state_next;
    logic [INIT_IDX_W-1:0]  init_idx;
    logic [INIT_IDX_W-1:0]  idx_succ;
    logic [7:0]             data_q;
    logic                   rs_q;
    logic                   en_q;
    logic                   ready;

    logic                   tmr_load;
    logic [CNT_W-1:0]       tmr_value;
    logic                   tmr_done;

    logic                   latch_en;
    logic [7:0]             latch_data;
    logic                   latch_rs;
    logic                   idx_inc;
    logic                   set_init_done;

    lcd_timer #(
        .WIDTH       (CNT_W),
        .RESET_VALUE (LD_POWERUP)
    ) u_timer (
        .clk        (CLOCK_50),
        .rst        (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    assign idx_succ    = init_idx + INIT_IDX_W'(1);
    assign ready       = (state == IDLE) && init_done;
    assign wr.wr_ready = ready;

    assign LCD_DATA = data_q;
    assign LCD_RS   = rs_q;
    assign LCD_EN   = en_q;
    assign LCD_RW   = 1'b0;
    assign LCD_ON   = 1'b1;
    assign LCD_BLON = 1'b1;

    // State register
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= PWRUP;
        end else begin
            state <= state_next;
        end
    end

    // Pin and bookkeeping registers. EN is registered from the next state so
    // it is high exactly during PULSE, and reset clears it without an edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            data_q    <= 8'h00;
            rs_q      <= 1'b0;
            init_idx  <= '0;
            init_done <= 1'b0;
        end else begin
            en_q <= (state_next == PULSE);
            if (latch_en) begin
                data_q <= latch_data;
                rs_q   <= latch_rs;
            end
            if (idx_inc) begin
                init_idx <= idx_succ;
            end
            if (set_init_done) begin
                init_done <= 1'b1;
            end
        end
    end

    // Next state; every timed state reloads the timer on its way out.
    // Data/RS are latched only when entering SETUP so they stay frozen
    // through SETUP, PULSE and WAIT.
    always_comb begin
        state_next    = state;
        tmr_load      = 1'b0;
        tmr_value     = '0;
        latch_en      = 1'b0;
        latch_data    = data_q;
        latch_rs      = rs_q;
        idx_inc       = 1'b0;
        set_init_done = 1'b0;

        case (state)
            PWRUP: begin
                if (tmr_done) begin
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_SETUP;
                    latch_en   = 1'b1;
                    latch_data = INIT_ROM[init_idx];
                    latch_rs   = 1'b0;
                end
            end

            SETUP: begin
                if (tmr_done) begin
                    state_next = PULSE;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_EN_HIGH;
                end
            end

            PULSE: begin
                if (tmr_done) begin
                    state_next = WAIT;
                    tmr_load   = 1'b1;
                    tmr_value  = needs_long_wait(rs_q, data_q) ? LD_CLEAR : LD_CMD;
                end
            end

            WAIT: begin
                if (tmr_done) begin
                    if (init_done) begin
                        state_next = IDLE;
                    end else if (init_idx == LAST_INIT) begin
                        state_next    = IDLE;
                        set_init_done = 1'b1;
                    end else begin
                        state_next = SETUP;
                        tmr_load   = 1'b1;
                        tmr_value  = LD_SETUP;
                        latch_en   = 1'b1;
                        latch_data = INIT_ROM[idx_succ];
                        latch_rs   = 1'b0;
                        idx_inc    = 1'b1;
                    end
                end
            end

            IDLE: begin
                if (wr.wr_valid && ready) begin
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = LD_SETUP;
                    latch_en   = 1'b1;
                    latch_data = wr.wr_data;
                    latch_rs   = wr.wr_rs;
                end
            end

            default: begin
                state_next = PWRUP;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_controller.sv
// tb_lcd_controller
// Self-checking bench for lcd_controller with short timing parameters.
// Expected pin behaviour is derived from the HD44780 write timing rules:
// each write is SETUP cycles of stable data, EN high for EN_HIGH cycles,
// then a wait that is long for clear/home commands and short otherwise.
module tb_lcd_controller;

    localparam int P_PWR   = 20;
    localparam int P_SETUP = 2;
    localparam int P_HIGH  = 3;
    localparam int P_CMD   = 10;
    localparam int P_CLEAR = 40;
    localparam int BUDGET  = 500;

    typedef struct {
        logic [7:0] d;
        logic       rs;
        int         gap;
    } item_t;

    logic       clock_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;
    logic       lcd_blon;

    lcd_if wr_bus ();

    lcd_controller #(
        .POWERUP_CYC    (P_PWR),
        .SETUP_CYC      (P_SETUP),
        .EN_HIGH_CYC    (P_HIGH),
        .CMD_WAIT_CYC   (P_CMD),
        .CLEAR_WAIT_CYC (P_CLEAR)
    ) dut (
        .CLOCK_50  (clock_50),
        .reset     (reset),
        .wr        (wr_bus),
        .init_done (init_done),
        .LCD_DATA  (lcd_data),
        .LCD_RS    (lcd_rs),
        .LCD_RW    (lcd_rw),
        .LCD_EN    (lcd_en),
        .LCD_ON    (lcd_on),
        .LCD_BLON  (lcd_blon)
    );

    always #5 clock_50 = ~clock_50;

    int         passed = 0;
    int         total  = 0;
    int         tick   = 0;
    int         rises  = 0;
    int         expected_pulses = 0;
    int         ready_while_busy = 0;
    logic       prev_en = 1'b0;

    int         last_fall;
    logic [7:0] last_d;
    logic       last_rs;
    int         offer_tick;
    logic [7:0] cur_d;
    logic       cur_rs;

    logic [7:0] init_cmds [0:4] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    item_t      items [$];

    // Post-pulse wait length for a written byte
    function automatic int wait_cycles(input logic [7:0] d, input logic rs);
        if (rs == 1'b0 && (d == 8'h01 || d == 8'h02)) return P_CLEAR;
        return P_CMD;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One sample per clock, taken on the falling edge
    task automatic step();
        @(negedge clock_50);
        tick++;
        if (lcd_en === 1'b1 && prev_en !== 1'b1) rises++;
        prev_en = lcd_en;
        if (wr_bus.wr_ready === 1'b1 && init_done !== 1'b1) ready_while_busy++;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic rs);
        wr_bus.wr_data  = d;
        wr_bus.wr_rs    = rs;
        wr_bus.wr_valid = 1'b1;
        cur_d      = d;
        cur_rs     = rs;
        offer_tick = tick;
    endtask

    task automatic capture_pulse(output int rise_t, output int fall_t, output logic [7:0] d,
                                 output logic r, output bit held, output bit ok);
        int n;
        ok     = 1'b0;
        held   = 1'b1;
        rise_t = tick;
        fall_t = tick;
        d      = 8'h00;
        r      = 1'b0;
        n      = 0;
        while (lcd_en !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (lcd_en !== 1'b1) return;
        rise_t = tick;
        d      = lcd_data;
        r      = lcd_rs;
        n      = 0;
        while (lcd_en === 1'b1 && n < BUDGET) begin
            step();
            n++;
            if (lcd_data !== d || lcd_rs !== r) held = 1'b0;
        end
        fall_t = tick;
        ok     = (lcd_en === 1'b0);
    endtask

    task automatic run_init(input int t0);
        int rise_t, fall_t;
        logic [7:0] d;
        logic r;
        bit held, ok;
        for (int i = 0; i < 5; i++) begin
            capture_pulse(rise_t, fall_t, d, r, held, ok);
            expected_pulses++;
            check_output("init_pulse_seen", 32'(ok), 32'd1);
            check_output("init_data", 32'(d), 32'(init_cmds[i]));
            check_output("init_rs", 32'(r), 32'd0);
            check_output("init_en_width", fall_t - rise_t, P_HIGH);
            check_output("init_held", 32'(held), 32'd1);
            if (i == 0) check_output("init_first_rise", rise_t - t0, P_PWR + P_SETUP);
            else check_output("init_gap", rise_t - last_fall, wait_cycles(last_d, last_rs) + P_SETUP);
            if (i == 4) check_output("init_done_early", 32'(init_done), 32'd0);
            last_fall = fall_t;
            last_d    = d;
            last_rs   = r;
        end
        check_output("ready_during_init", ready_while_busy, 0);
    endtask

    task automatic run_transaction(input bit has_next, input logic [7:0] nd, input logic nrs);
        int n, accept_t, exp_accept, rise_t, fall_t;
        logic [7:0] d, my_d;
        logic r, my_rs;
        bit held, ok;
        my_d  = cur_d;
        my_rs = cur_rs;
        n     = 0;
        while (wr_bus.wr_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        check_output("accept_ready", 32'(wr_bus.wr_ready), 32'd1);
        exp_accept = last_fall + wait_cycles(last_d, last_rs);
        if (offer_tick > exp_accept) exp_accept = offer_tick;
        check_output("accept_tick", tick, exp_accept);
        check_output("idle_data_hold", 32'(lcd_data), 32'(last_d));
        check_output("idle_init_done", 32'(init_done), 32'd1);
        accept_t = tick;
        step();
        expected_pulses++;
        check_output("ready_drop", 32'(wr_bus.wr_ready), 32'd0);
        check_output("setup_data", 32'(lcd_data), 32'(my_d));
        check_output("setup_rs", 32'(lcd_rs), 32'(my_rs));
        check_output("setup_en_low", 32'(lcd_en), 32'd0);
        if (has_next) apply_stimulus(nd, nrs);
        else wr_bus.wr_valid = 1'b0;
        capture_pulse(rise_t, fall_t, d, r, held, ok);
        check_output("pulse_seen", 32'(ok), 32'd1);
        check_output("rise_latency", rise_t - accept_t, P_SETUP + 1);
        check_output("en_width", fall_t - rise_t, P_HIGH);
        check_output("pulse_data", 32'(d), 32'(my_d));
        check_output("pulse_rs", 32'(r), 32'(my_rs));
        check_output("pulse_held", 32'(held), 32'd1);
        last_fall = fall_t;
        last_d    = my_d;
        last_rs   = my_rs;
    endtask

    initial begin
        int t0, n;
        item_t it;

        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_data  = 8'h00;
        wr_bus.wr_rs    = 1'b0;
        reset           = 1'b1;
        repeat (3) step();

        check_output("rst_en", 32'(lcd_en), 32'd0);
        check_output("rst_rs", 32'(lcd_rs), 32'd0);
        check_output("rst_data", 32'(lcd_data), 32'h00);
        check_output("rst_ready", 32'(wr_bus.wr_ready), 32'd0);
        check_output("rst_init_done", 32'(init_done), 32'd0);
        check_output("pin_rw", 32'(lcd_rw), 32'd0);
        check_output("pin_on", 32'(lcd_on), 32'd1);
        check_output("pin_blon", 32'(lcd_blon), 32'd1);

        // Directed bytes first, then a random mix biased toward clear/home
        items.push_back('{d: 8'h41, rs: 1'b1, gap: 0});
        items.push_back('{d: 8'h42, rs: 1'b1, gap: 0});
        items.push_back('{d: 8'h01, rs: 1'b0, gap: 2});
        items.push_back('{d: 8'h03, rs: 1'b0, gap: 0});
        items.push_back('{d: 8'h02, rs: 1'b0, gap: 5});
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                it.d  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
                it.rs = 1'($urandom_range(0, 1));
            end else begin
                it.d  = 8'($urandom_range(0, 255));
                it.rs = 1'($urandom_range(0, 1));
            end
            it.gap = $urandom_range(0, 15);
            items.push_back(it);
        end

        // First byte is offered while the display is still initialising
        apply_stimulus(items[0].d, items[0].rs);
        reset = 1'b0;
        t0    = tick;
        run_init(t0);

        for (int i = 0; i < items.size(); i++) begin
            if (wr_bus.wr_valid !== 1'b1) begin
                repeat (items[i].gap) step();
                apply_stimulus(items[i].d, items[i].rs);
            end
            if (i + 1 < items.size() && items[i + 1].gap == 0)
                run_transaction(1'b1, items[i + 1].d, items[i + 1].rs);
            else
                run_transaction(1'b0, 8'h00, 1'b0);
        end

        // Abort a write on the second PULSE cycle
        repeat (4) step();
        apply_stimulus(8'h5A, 1'b1);
        n = 0;
        while (wr_bus.wr_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        check_output("abort_accept", 32'(wr_bus.wr_ready), 32'd1);
        step();
        expected_pulses++;
        wr_bus.wr_valid = 1'b0;
        n = 0;
        while (lcd_en !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        check_output("abort_en_rose", 32'(lcd_en), 32'd1);
        @(posedge clock_50);
        #2;
        reset = 1'b1;
        #1;
        check_output("abort_en_async", 32'(lcd_en), 32'd0);
        check_output("abort_init_done", 32'(init_done), 32'd0);
        check_output("abort_ready", 32'(wr_bus.wr_ready), 32'd0);
        check_output("abort_data", 32'(lcd_data), 32'h00);
        check_output("abort_rs", 32'(lcd_rs), 32'd0);

        apply_stimulus(8'h7E, 1'b1);
        step();
        step();
        reset            = 1'b0;
        ready_while_busy = 0;
        t0               = tick;
        run_init(t0);
        run_transaction(1'b0, 8'h00, 1'b0);

        repeat (60) step();
        check_output("pulse_count", rises, expected_pulses);
        check_output("final_ready", 32'(wr_bus.wr_ready), 32'd1);
        check_output("final_en", 32'(lcd_en), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
